// File: rtl/decoder_4to8_hold_pkg.sv
// Shared definitions for the 4-to-8 hold decoder.
// Covers the state encoding, the code field layout and the one-hot width.
package decoder_4to8_hold_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Codes come from the 8-to-4 priority encoder as {flag, index[2:0]}.
    localparam int CODE_W   = 4;
    localparam int IDX_W    = 3;
    localparam int ONEHOT_W = 8;

    localparam int FLAG_BIT = 3;
    localparam int IDX_MSB  = 2;
    localparam int IDX_LSB  = 0;

endpackage : decoder_4to8_hold_pkg

// File: rtl/decoder_4to8_hold_if.sv
// Valid/ready code-in, one-hot-out bus of the hold decoder.
// Clock and reset stay outside the bundle.
interface decoder_4to8_hold_if;
    import decoder_4to8_hold_pkg::*;

    logic                i_en;
    logic                i_valid;
    logic [CODE_W-1:0]   i_num;
    logic                o_ready;
    logic                o_valid;
    logic [ONEHOT_W-1:0] o_num;

    // Upstream side: drives the code and the enable.
    modport master (
        output i_en, i_valid, i_num,
        input  o_ready, o_valid, o_num
    );

    // Decoder side.
    modport slave (
        input  i_en, i_valid, i_num,
        output o_ready, o_valid, o_num
    );

endinterface : decoder_4to8_hold_if

// File: rtl/decoder_4to8_hold_decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder.
// The output is all zeros while the decoder is disabled.
module decoder_3to8
    import decoder_4to8_hold_pkg::*;
(
    input  logic                i_en,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [ONEHOT_W-1:0] o_onehot
);

    // NOTE: assign a default to every always_comb output first; otherwise
    // the disabled path would leave o_onehot unassigned and infer a latch.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule : decoder_3to8

// File: rtl/decoder_4to8_hold.sv
// Registered 4-to-8 decoder that holds each accepted code for HOLD_CYCLES
// enabled cycles. The display blanks while paused, and the decoder goes idle once the hold ends.
module decoder_4to8_hold
    import decoder_4to8_hold_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    decoder_4to8_hold_if.slave bus
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CODE_W-1:0]   code, code_d;
    logic [ONEHOT_W-1:0] num_q, onehot;
    logic                at_last, ready, accept, dec_en;

    assign at_last = (cnt == CNT_LAST);
    assign ready   = !i_rst && bus.i_en &&
                     ((state == IDLE) || ((state == SHOW) && at_last));
    assign accept  = bus.i_valid && ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        code_d  = code;
        if (accept) begin
            // A new code at the last hold cycle replaces the old one with no gap.
            state_d = SHOW;
            cnt_d   = '0;
            code_d  = bus.i_num;
        end else if ((state == SHOW) && bus.i_en) begin
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    // The decode follows the code that will be held next cycle.
    // This gives a fresh code one cycle of latency and blanks the display while paused.
    assign dec_en = code_d[FLAG_BIT] && bus.i_en && (state_d == SHOW);

    decoder_3to8 u_dec (
        .i_en     (dec_en),
        .i_idx    (code_d[IDX_MSB:IDX_LSB]),
        .o_onehot (onehot)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
            num_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            code  <= code_d;
            num_q <= onehot;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = (state == SHOW);
    assign bus.o_num   = num_q;

    a_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(num_q));
    a_blank_idle : assert property (@(posedge i_clk) disable iff (i_rst)
        (state != SHOW) |-> (num_q == '0));

endmodule : decoder_4to8_hold

// File: tb/tb_decoder_4to8_hold.sv
// Self-checking bench for decoder_4to8_hold with HOLD_CYCLES = 4 and 1.
// Both instances see the same stimulus, and a countdown model predicts their outputs.
module tb_decoder_4to8_hold;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_4to8_hold_if bus4 ();
    decoder_4to8_hold_if bus1 ();

    decoder_4to8_hold #(.HOLD_CYCLES(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
    decoder_4to8_hold #(.HOLD_CYCLES(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    bit compare_on = 1'b0;

    // Shared input values, mirrored onto both buses.
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] num = 4'h0;

    assign bus4.i_en = en;  assign bus4.i_valid = valid;  assign bus4.i_num = num;
    assign bus1.i_en = en;  assign bus1.i_valid = valid;  assign bus1.i_num = num;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a held code has 'rem' enabled display cycles left.
    int         hold_len [2] = '{4, 1};
    bit         m_busy   [2] = '{1'b0, 1'b0};
    int         m_rem    [2] = '{0, 0};
    logic [3:0] m_code   [2] = '{4'h0, 4'h0};
    logic [7:0] m_onum   [2] = '{8'h00, 8'h00};

    function automatic logic [7:0] show(input logic [3:0] c);
        int v;
        v = c[3] ? (2 ** int'(c[2:0])) : 0;
        return v[7:0];
    endfunction

    function automatic logic m_ready(input int k);
        return !rst && en && (!m_busy[k] || m_rem[k] == 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0; m_rem[k] <= 0; m_code[k] <= 4'h0; m_onum[k] <= 8'h00;
            end else if (valid && m_ready(k)) begin
                m_busy[k] <= 1'b1; m_rem[k] <= hold_len[k]; m_code[k] <= num;
                m_onum[k] <= show(num);
            end else if (m_busy[k] && en) begin
                m_rem[k]  <= m_rem[k] - 1;
                m_busy[k] <= (m_rem[k] > 1);
                m_onum[k] <= (m_rem[k] > 1) ? show(m_code[k]) : 8'h00;
            end else begin
                m_onum[k] <= 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check("h4_ready", bus4.o_ready, m_ready(0));
            check("h4_valid", bus4.o_valid, m_busy[0]);
            check("h4_num",   bus4.o_num,   m_onum[0]);
            check("h1_ready", bus1.o_ready, m_ready(1));
            check("h1_valid", bus1.o_valid, m_busy[1]);
            check("h1_num",   bus1.o_num,   m_onum[1]);
        end
    end

    // One clock: apply inputs, then return just after the edge.
    task automatic cyc(input logic e, input logic v, input logic [3:0] n);
        en = e; valid = v; num = n;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_pause [6] = '{8'h04, 8'h04, 8'h00, 8'h00, 8'h04, 8'h04};
    logic       en_pause  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1;
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0);
        compare_on = 1'b1;
        check("rst_valid", bus4.o_valid, 1'b0);
        check("rst_num",   bus4.o_num,   8'h00);
        check("rst_ready", bus4.o_ready, 1'b0);
        rst = 1'b0;

        // Single code, four-cycle hold.
        cyc(1'b1, 1'b1, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", bus4.o_valid, 1'b1);
            check("t1_num",   bus4.o_num,   8'b0010_0000);
            cyc(1'b1, 1'b0, 4'h0);
        end
        check("t1_idle_valid", bus4.o_valid, 1'b0);
        check("t1_idle_num",   bus4.o_num,   8'h00);
        check("t1_idle_ready", bus4.o_ready, 1'b1);

        // Flag clear: held with a blank display.
        cyc(1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", bus4.o_valid, 1'b1);
            check("t2_num",   bus4.o_num,   8'h00);
            check("t2_ready", bus4.o_ready, (i == 3));
            cyc(1'b1, 1'b0, 4'h0);
        end
        check("t2_idle_valid", bus4.o_valid, 1'b0);

        // Back-to-back codes with i_valid held high.
        cyc(1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            check("t3_num_a", bus4.o_num, 8'h01);
            check("t3_valid", bus4.o_valid, 1'b1);
            cyc(1'b1, 1'b1, 4'b1111);
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_num_b", bus4.o_num, 8'h80);
            check("t3_valid", bus4.o_valid, 1'b1);
            cyc(1'b1, 1'b0, 4'h0);
        end
        check("t3_idle_valid", bus4.o_valid, 1'b0);

        // Pause for two cycles at cnt==1.
        cyc(1'b1, 1'b1, 4'b1010);
        for (int i = 0; i < 6; i++) begin
            check("t4_valid", bus4.o_valid, 1'b1);
            check("t4_num",   bus4.o_num,   exp_pause[i]);
            cyc(en_pause[i], !en_pause[i], 4'b1111);
        end
        check("t4_idle_valid", bus4.o_valid, 1'b0);
        check("t4_idle_num",   bus4.o_num,   8'h00);

        // Reset in the middle of a hold.
        cyc(1'b1, 1'b1, 4'b1101);
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 4'b1001);
        check("t5_valid", bus4.o_valid, 1'b0);
        check("t5_num",   bus4.o_num,   8'h00);
        check("t5_ready_in_rst", bus4.o_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("t5_ready_after", bus4.o_ready, 1'b1);
        cyc(1'b1, 1'b0, 4'h0);
        check("t5_not_captured", bus4.o_valid, 1'b0);

        // HOLD_CYCLES=1 streaming.
        cyc(1'b1, 1'b1, 4'b1000);
        check("t6_num0", bus1.o_num, 8'h01);
        cyc(1'b1, 1'b1, 4'b1001);
        check("t6_num1", bus1.o_num, 8'h02);
        cyc(1'b1, 1'b1, 4'b1010);
        check("t6_num2", bus1.o_num, 8'h04);
        cyc(1'b1, 1'b0, 4'h0);
        check("t6_end_num",   bus1.o_num,   8'h00);
        check("t6_end_valid", bus1.o_valid, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cyc(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        cyc(1'b1, 1'b0, 4'h0);

        @(negedge clk);
        compare_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_decoder_4to8_hold

// File: doc/decoder_4to8_hold.md
Name: decoder_4to8_hold

Overview:
- Registered inverse of the team's 8-to-4 priority encoder.
- Accepts 4-bit codes {flag, index[2:0]} through a valid/ready handshake and decodes each into an 8-bit one-hot pattern.
- Holds each pattern on the output for a programmable number of enabled cycles, then goes idle.
- Sits downstream of the encoder, driving LED/display style consumers that need a stable one-hot for several cycles.

Parameters:
- HOLD_CYCLES, 4, enabled cycles each accepted code is displayed; legal range 1..255.
- CNT_W, derived localparam ($clog2 of HOLD_CYCLES, minimum 1), width of the hold counter; not overridable.

Ports:
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_en  input  1  global enable; 0 pauses the hold counter, blanks o_num and blocks acceptance.
- i_valid  input  1  upstream has a code on i_num.
- i_num  input  4  bit3 = code-valid flag, bits[2:0] = index (encoder output format).
- o_ready  output  1  block accepts i_num this cycle.
- o_valid  output  1  a code is currently being held (state SHOW).
- o_num  output  8  registered one-hot decode of the held code; 8'h00 when idle, blanked or flag=0.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - state=IDLE, cnt=0, held code=0, o_valid=0, o_num=8'h00.
  - o_ready is forced 0 while i_rst=1.
  - Reset mid-SHOW drops the held code and any input presented in that cycle.
- States:
  - IDLE: nothing held.
  - SHOW: code held, counting.
  - Encoding lives in the shared package as 1-bit constants.
- o_ready (combinational) = !i_rst && i_en && (state==IDLE || (state==SHOW && cnt==HOLD_CYCLES-1)).
- Accept = i_valid && o_ready.
- On accept:
  - Capture i_num; next state SHOW; cnt=0.
  - Next cycle o_valid=1.
  - Next cycle o_num = i_num[3] ? (8'b1 << i_num[2:0]) : 8'h00.
  - Latency is exactly 1 cycle.
- Flag=0 codes are accepted and held like any other: o_valid=1, o_num=8'h00 for the full hold.
- SHOW with i_en=1:
  - If cnt < HOLD_CYCLES-1: cnt increments.
  - If cnt == HOLD_CYCLES-1 and accept: reload with the new code, cnt=0, no idle gap (back-to-back).
  - If cnt == HOLD_CYCLES-1 and no accept: next state IDLE, o_valid=0, o_num=8'h00.
- SHOW with i_en=0:
  - cnt and state freeze; o_valid stays 1.
  - o_num register loads 8'h00, visible 1 cycle after i_en falls.
  - The decoded value returns 1 cycle after i_en rises.
  - The hold is extended by the paused cycles.
- IDLE with i_en=0: no accept, outputs stay 0.
- HOLD_CYCLES=1: o_ready is high every enabled cycle, so one code per cycle streams through.
- o_num is always either 8'h00 or exactly one bit set.
- o_num is 8'h00 whenever o_valid=0.

Decomposition:
- Shared package/header holds:
  - state constants (IDLE, SHOW);
  - code field widths (CODE_W=4, IDX_W=3, ONEHOT_W=8);
  - code-field bit positions (flag=3, index=2:0).
- One sub-module: decoder_3to8.
  - Purely combinational: i_en, i_idx[2:0] -> o_onehot[7:0].
  - Outputs 0 when not enabled.
  - Instantiated with enable = held flag && i_en; its output feeds the o_num register.

Test Plan:
- Reset, then i_num=4'b1101 with i_valid for 1 cycle, i_en=1 -> one cycle later o_valid=1, o_num=8'b0010_0000 for 4 cycles; then o_valid=0, o_num=8'h00, o_ready=1.
- i_num=4'b0110 accepted -> o_valid=1 with o_num=8'h00 for 4 cycles; o_ready=0 during cycles 1-3 of the hold.
- i_valid held high, 4'b1000 then 4'b1111 presented at cnt==3 -> o_num 8'h01 for 4 cycles then 8'h80 for 4 cycles, no gap; o_valid continuously 1.
- i_en=0 for 2 cycles at cnt==1 while holding 4'b1010 -> o_num 8'h00 for 2 cycles (1-cycle lag), o_valid stays 1, total hold 6 cycles; i_valid ignored while i_en=0.
- i_rst=1 at cnt==2 with i_valid=1 -> next edge o_valid=0, o_num=8'h00, input not captured; o_ready=1 the cycle i_rst drops.
- HOLD_CYCLES=1, codes 4'b1000, 4'b1001, 4'b1010 on consecutive cycles -> o_num 8'h01, 8'h02, 8'h04 on consecutive cycles, then 8'h00.
